// File: rtl/lcd_cmd_issuer_pkg.sv
// Shared command codes, FSM state type and helpers for the LCD command issuer.
package lcd_ctrl_pkg;

  localparam int CMD_W = 4;

  localparam logic [CMD_W-1:0] CMD_WRITE       = 4'h0;
  localparam logic [CMD_W-1:0] CMD_SHIFT_UP    = 4'h1;
  localparam logic [CMD_W-1:0] CMD_SHIFT_DOWN  = 4'h2;
  localparam logic [CMD_W-1:0] CMD_SHIFT_LEFT  = 4'h3;
  localparam logic [CMD_W-1:0] CMD_SHIFT_RIGHT = 4'h4;
  localparam logic [CMD_W-1:0] CMD_MAX         = 4'h5;
  localparam logic [CMD_W-1:0] CMD_MIN         = 4'h6;
  localparam logic [CMD_W-1:0] CMD_AVERAGE     = 4'h7;
  localparam logic [CMD_W-1:0] CMD_ROTATE_CCW  = 4'h8;
  localparam logic [CMD_W-1:0] CMD_ROTATE_CW   = 4'h9;
  localparam logic [CMD_W-1:0] CMD_MIRROR_X    = 4'hA;
  localparam logic [CMD_W-1:0] CMD_MIRROR_Y    = 4'hB;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    GAP      = 3'd2,
    DRAIN_WR = 3'd3,
    FINISH   = 3'd4
  } issuer_state_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] code);
    return (code <= CMD_MIRROR_Y);
  endfunction

  // Saturating 8-bit increment used by the event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lcd_cmd_issuer_if.sv
// Push-side and controller-side handshake of the LCD command issuer.
interface lcd_cmd_issuer_if;
  import lcd_ctrl_pkg::*;

  logic [CMD_W-1:0] push_cmd;
  logic             push_valid;
  logic             push_ready;
  logic [CMD_W-1:0] cmd;
  logic             cmd_valid;
  logic             busy;
  logic             done;

  modport master (
    input  push_cmd, push_valid, busy, done,
    output push_ready, cmd, cmd_valid
  );

  modport slave (
    output push_cmd, push_valid, busy, done,
    input  push_ready, cmd, cmd_valid
  );

endinterface

// File: rtl/lcd_cmd_issuer_fifo.sv
// Synchronous command FIFO with registered occupancy and full/empty flags.
module lcd_cmd_fifo
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_en,
  input  logic [CMD_W-1:0] wr_data,
  input  logic             pop_en,
  output logic [CMD_W-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push_en && !full;
  assign do_pop_s  = pop_en && !empty;
  assign rd_data   = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1'b1);
        2'b01:   count_r <= count_r - (AW+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lcd_cmd_issuer.sv
// LCD command issuer: queues commands and strobes them to the LCD controller.
// Optional LCD_CMD_CHECK_EN drops illegal codes (C-F) and counts them on drop_cnt.
module lcd_cmd_issuer
  import lcd_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  lcd_cmd_issuer_if.master     bus,
  output logic [7:0]           issued_cnt,
  output logic                 seq_done
`ifdef LCD_CMD_CHECK_EN
  ,
  output logic [7:0]           drop_cnt
`endif
);

  issuer_state_t    state_r, state_nxt_s;
  logic [CMD_W-1:0] cmd_r, cmd_nxt_s;
  logic             cmd_valid_r, cmd_valid_nxt_s;
  logic [7:0]       issued_cnt_r, issued_cnt_nxt_s;
  logic             seq_done_r, seq_done_nxt_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [CMD_W-1:0] head_s;
`ifdef LCD_CMD_CHECK_EN
  logic [7:0]       drop_cnt_r, drop_cnt_nxt_s;
  assign drop_cnt = drop_cnt_r;
`endif

  assign bus.push_ready = !full_s && (state_r != FINISH) && (state_r != DRAIN_WR);
  assign push_s         = bus.push_valid && bus.push_ready;
  assign bus.cmd        = cmd_r;
  assign bus.cmd_valid  = cmd_valid_r;
  assign issued_cnt     = issued_cnt_r;
  assign seq_done       = seq_done_r;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_en (push_s),
    .wr_data (bus.push_cmd),
    .pop_en  (pop_s),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Next-state and next-output logic of the issue sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    cmd_nxt_s        = cmd_r;
    cmd_valid_nxt_s  = 1'b0;
    issued_cnt_nxt_s = issued_cnt_r;
    seq_done_nxt_s   = seq_done_r;
    pop_s            = 1'b0;
`ifdef LCD_CMD_CHECK_EN
    drop_cnt_nxt_s   = drop_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (!empty_s && !bus.busy) begin
          pop_s = 1'b1;
`ifdef LCD_CMD_CHECK_EN
          if (!cmd_is_legal(head_s)) begin
            drop_cnt_nxt_s = sat_inc8(drop_cnt_r);
          end else begin
            state_nxt_s      = ISSUE;
            cmd_nxt_s        = head_s;
            cmd_valid_nxt_s  = 1'b1;
            issued_cnt_nxt_s = sat_inc8(issued_cnt_r);
          end
`else
          state_nxt_s      = ISSUE;
          cmd_nxt_s        = head_s;
          cmd_valid_nxt_s  = 1'b1;
          issued_cnt_nxt_s = sat_inc8(issued_cnt_r);
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = GAP;
      end
      // cmd_r still holds the command just issued, so it selects the exit.
      GAP: begin
        if (cmd_r == CMD_WRITE) begin
          state_nxt_s = DRAIN_WR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN_WR: begin
        if (bus.done) begin
          state_nxt_s    = FINISH;
          seq_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = DRAIN_WR;
        end
      end
      FINISH: begin
        state_nxt_s = FINISH;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      cmd_r        <= 4'h0;
      cmd_valid_r  <= 1'b0;
      issued_cnt_r <= 8'd0;
      seq_done_r   <= 1'b0;
`ifdef LCD_CMD_CHECK_EN
      drop_cnt_r   <= 8'd0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      cmd_r        <= cmd_nxt_s;
      cmd_valid_r  <= cmd_valid_nxt_s;
      issued_cnt_r <= issued_cnt_nxt_s;
      seq_done_r   <= seq_done_nxt_s;
`ifdef LCD_CMD_CHECK_EN
      drop_cnt_r   <= drop_cnt_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Scoreboard bench for lcd_cmd_issuer; honours LCD_CMD_CHECK_EN when defined.
module tb_lcd_cmd_issuer;
  import lcd_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] issued_cnt;
  logic       seq_done;
`ifdef LCD_CMD_CHECK_EN
  logic [7:0] drop_cnt;
`endif

  lcd_cmd_issuer_if bus ();

  lcd_cmd_issuer #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .issued_cnt (issued_cnt),
    .seq_done   (seq_done)
`ifdef LCD_CMD_CHECK_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the ordered list of strobes the controller must see.
  logic [3:0] exp_q[$];
  int  exp_issued = 0;
  int  exp_drop = 0;
  bit  model_stopped = 1'b0;

  bit hold_busy = 1'b0;
  bit auto_busy = 1'b0;
  bit done_man = 1'b0;
  bit done_auto = 1'b0;
  assign bus.busy = hold_busy | auto_busy;
  assign bus.done = done_man | done_auto;

  int cyc = 0;
  bit busy_q = 1'b0;
  int strobe_n = 0;
  int last_strobe = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // An accepted command is issued unless a write is already ahead of it.
  function automatic void model_accept(input logic [3:0] c);
    if (model_stopped) return;
`ifdef LCD_CMD_CHECK_EN
    if (c > 4'hB) begin
      exp_drop++;
      return;
    end
`endif
    exp_q.push_back(c);
    exp_issued++;
    if (c == 4'h0) model_stopped = 1'b1;
  endfunction

  task automatic push_try(input logic [3:0] c, output bit acc);
    @(posedge clk);
    #1;
    bus.push_cmd   = c;
    bus.push_valid = 1'b1;
    @(negedge clk);
    acc = bus.push_ready;
    @(posedge clk);
    if (acc) model_accept(c);
    #1;
    bus.push_valid = 1'b0;
  endtask

  task automatic do_reset(input bit busy_val);
    hold_busy = busy_val;
    done_man  = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    exp_issued    = 0;
    exp_drop      = 0;
    model_stopped = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd", bus.cmd, 0);
    check("rst_issued_cnt", issued_cnt, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_push_ready", bus.push_ready, 1);
`ifdef LCD_CMD_CHECK_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (15) @(posedge clk);
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= bus.busy;
  end

  // Monitor: every strobe is compared against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        strobe_n    = 0;
        last_strobe = -100;
      end else if (bus.cmd_valid) begin
        strobe_n++;
        check("busy_at_issue", busy_q, 0);
        check("strobe_spacing", (cyc - last_strobe) >= 3, 1);
        last_strobe = cyc;
        check("issued_cnt_live", issued_cnt, strobe_n);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe actual=%0h expected=none", bus.cmd);
        end else begin
          check("strobe_cmd", bus.cmd, exp_q.pop_front());
        end
      end
    end
  end

  // LCD controller stand-in: busy for 4 cycles after each strobe, done after a write.
  initial begin : ctrl
    logic [3:0] c;
    forever begin
      @(negedge clk);
      if (bus.cmd_valid && !reset) begin
        c = bus.cmd;
        @(posedge clk);
        #1 auto_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 auto_busy = 1'b0;
        if (c == 4'h0 && !reset) begin
          done_auto = 1'b1;
          @(posedge clk);
          #1 done_auto = 1'b0;
          @(negedge clk);
          check("seq_done_after_done", seq_done, 1);
          check("push_ready_finish", bus.push_ready, 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    logic [3:0] c;
    bus.push_cmd   = 4'h0;
    bus.push_valid = 1'b0;

    // Reset values, then reset with busy held: nothing may issue.
    do_reset(1'b0);
    do_reset(1'b1);
    push_try(4'h7, acc);
    check("busy_hold_accept", acc, 1);
    repeat (6) @(posedge clk);
    #1;
    check("busy_hold_no_issue", issued_cnt, 0);
    hold_busy = 1'b0;
    wait_drain(100);

    // Basic sequence 1, 9, 0 with first-strobe latency check.
    do_reset(1'b0);
    push_try(4'h1, acc);
    @(negedge clk);
    check("latency_not_yet", bus.cmd_valid, 0);
    @(negedge clk);
    check("latency_strobe", bus.cmd_valid, 1);
    push_try(4'h9, acc);
    push_try(4'h0, acc);
    check("basic_seq_done_early", seq_done, 0);
    wait_drain(200);
    check("basic_issued", issued_cnt, 3);
    check("basic_seq_done", seq_done, 1);

    // FIFO full: 16 accepted, 17th refused, then drained in order.
    do_reset(1'b1);
    for (int i = 0; i < 17; i++) begin
      push_try(4'((i % 11) + 1), acc);
      check("full_accept", acc, (i < 16) ? 1 : 0);
    end
    hold_busy = 1'b0;
    wait_drain(400);
    check("full_issued", issued_cnt, 16);

    // Stop at write: early done ignored, trailing command never issued.
    do_reset(1'b1);
    push_try(4'h0, acc);
    push_try(4'h3, acc);
    @(posedge clk);
    #1 done_man = 1'b1;
    @(posedge clk);
    #1 done_man = 1'b0;
    @(negedge clk);
    check("early_done_ignored", seq_done, 0);
    hold_busy = 1'b0;
    wait_drain(100);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("stop_issued", issued_cnt, 1);
    check("stop_seq_done", seq_done, 1);
    check("stop_push_ready", bus.push_ready, 0);

    // Illegal code followed by a legal one.
    do_reset(1'b0);
    push_try(4'hC, acc);
    push_try(4'h5, acc);
    wait_drain(100);
`ifdef LCD_CMD_CHECK_EN
    check("illegal_issued", issued_cnt, 1);
    check("illegal_drop", drop_cnt, 1);
`else
    check("illegal_issued", issued_cnt, 2);
`endif

    // Reset during GAP of the first command.
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) push_try(4'(i + 1), acc);
    hold_busy = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_strobe_seen", bus.cmd_valid, 1);
    @(posedge clk);
    #1;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_reset_quiet", bus.cmd_valid, 0);
    end
    check("post_reset_issued", issued_cnt, 0);

    // Randomized rounds against the reference model.
    for (int r = 0; r < 6; r++) begin
      do_reset(1'b0);
      n = $urandom_range(3, 12);
      for (int k = 0; k < n; k++) begin
        if (k == n - 1 && $urandom_range(0, 1) == 1) c = 4'h0;
        else c = 4'($urandom_range(1, 15));
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) push_try(c, acc);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_drain(1000);
      check("rand_issued", issued_cnt, exp_issued);
      check("rand_seq_done", seq_done, model_stopped);
`ifdef LCD_CMD_CHECK_EN
      check("rand_drop", drop_cnt, exp_drop);
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
